// File: rtl/bitser_pkg.sv
// ---------------------------------------------------------------------------
// bitser_pkg
// Shared definitions for the word-to-bit-serial transmitter.
//   BITSER_WIDTH_DEFAULT : default operand width (bits and flits per word)
//   cnt_w()              : width of the flit counter for a given operand width
//   route_e              : where an accepted input word is steered
// ---------------------------------------------------------------------------
package bitser_pkg;

   localparam int BITSER_WIDTH_DEFAULT = 8;

   // A 1-bit word still needs a 1-bit counter, so clamp at 1.
   function automatic int cnt_w(input int width);
      int w;
      w = $clog2(width);
      return (w < 1) ? 1 : w;
   endfunction

   typedef enum logic [1:0] {
      ROUTE_NONE = 2'd0,
      ROUTE_SR   = 2'd1,
      ROUTE_HR   = 2'd2
   } route_e;

endpackage

// File: rtl/bitser_tx_if.sv
// ---------------------------------------------------------------------------
// bitser_tx_if
// Word-side and serial-side handshake bundle of bitser_tx.
//   Word side   : i_A, i_B (WIDTH), i_vld, o_rdy
//   Serial side : o_A, o_B, o_vld, o_last, i_rdy
// Modports:
//   slave  - the transmitter (consumes words, produces flits)
//   master - the environment (produces words, consumes flits)
// ---------------------------------------------------------------------------
interface bitser_tx_if #(
   parameter int WIDTH = bitser_pkg::BITSER_WIDTH_DEFAULT
);
   logic [WIDTH-1:0] i_A;
   logic [WIDTH-1:0] i_B;
   logic             i_vld;
   logic             o_rdy;
   logic             o_A;
   logic             o_B;
   logic             o_vld;
   logic             o_last;
   logic             i_rdy;

   modport slave (
      input  i_A, i_B, i_vld, i_rdy,
      output o_rdy, o_A, o_B, o_vld, o_last
   );

   modport master (
      output i_A, i_B, i_vld, i_rdy,
      input  o_rdy, o_A, o_B, o_vld, o_last
   );
endinterface

// File: rtl/bitser_shreg.sv
// ---------------------------------------------------------------------------
// bitser_shreg
// Loadable right-shift register holding one {A,B} operand pair. Both
// operands shift together so bit 0 of each is always the current flit.
//   clk   : clock
//   load  : parallel load of din (wins over shift)
//   shift : shift both operands right by one
//   din   : parallel pair, packed as {a, b}
//   bit_a : bit 0 of the held A
//   bit_b : bit 0 of the held B
// Data path only: no reset, validity is tracked by the owner.
// ---------------------------------------------------------------------------
module bitser_shreg #(
   parameter int WIDTH = bitser_pkg::BITSER_WIDTH_DEFAULT
) (
   input  logic               clk,
   input  logic               load,
   input  logic               shift,
   input  logic [2*WIDTH-1:0] din,
   output logic               bit_a,
   output logic               bit_b
);
   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } operand_pair_t;

   operand_pair_t din_pair;
   operand_pair_t sr;

   assign din_pair = din;

   always_ff @(posedge clk) begin
      if (load) begin
         sr <= din_pair;
      end else if (shift) begin
         sr.a <= sr.a >> 1;
         sr.b <= sr.b >> 1;
      end
   end

   assign bit_a = sr.a[0];
   assign bit_b = sr.b[0];
endmodule

// File: rtl/mm_flop.sv
// ---------------------------------------------------------------------------
// mm_flop
// Single-bit control flop with synchronous active-low reset to 0.
//   clk   : clock
//   rst_n : synchronous reset, active-low
//   d     : next value
//   q     : registered value
// ---------------------------------------------------------------------------
module mm_flop (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   always_ff @(posedge clk) begin
      if (!rst_n) q <= 1'b0;
      else        q <= d;
   end
endmodule

// File: rtl/bitser_tx.sv
// ---------------------------------------------------------------------------
// bitser_tx
// Word-to-bit-serial transmitter. Accepts an {A,B} operand pair per word
// handshake and emits it LSB first as WIDTH lock-step flits, o_last on the
// MSB flit. A one-word holding register (HR) behind the shift register (SR)
// lets the next word be taken while the current one shifts, so consecutive
// words leave with no bubble.
//   i_clk     : clock, all state on the rising edge
//   i_reset_n : synchronous reset, active-low
//   bus       : bitser_tx_if slave (i_A/i_B/i_vld/o_rdy word side,
//               o_A/o_B/o_vld/o_last/i_rdy serial side)
// ---------------------------------------------------------------------------
module bitser_tx
   import bitser_pkg::*;
#(
   parameter int WIDTH = BITSER_WIDTH_DEFAULT
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   bitser_tx_if.slave bus
);
   localparam int            CW       = cnt_w(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } operand_pair_t;

   operand_pair_t in_pair;
   operand_pair_t hr;
   operand_pair_t sr_din;

   logic          sr_full, sr_full_nxt;
   logic          hr_full, hr_full_nxt;
   logic          rdy;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          bit_a, bit_b;

   logic          is_last, xfer_out, xfer_in;
   logic          sr_frees, sr_shift, sr_load, hr_to_sr;
   route_e        route;

   assign in_pair.a = bus.i_A;
   assign in_pair.b = bus.i_B;

   assign is_last  = (cnt == CNT_LAST);
   assign xfer_out = sr_full && bus.i_rdy;
   assign xfer_in  = bus.i_vld && rdy;
   assign sr_frees = xfer_out && is_last;
   assign sr_shift = xfer_out && !is_last;
   assign hr_to_sr = sr_frees && hr_full;

   // A new word may enter SR only when nothing older is waiting in HR;
   // otherwise it queues in HR, which keeps word order intact.
   always_comb begin
      route = ROUTE_NONE;
      if (xfer_in) begin
         if (!sr_full || (sr_frees && !hr_full)) route = ROUTE_SR;
         else                                    route = ROUTE_HR;
      end
   end

   assign sr_load = hr_to_sr || (route == ROUTE_SR);
   assign sr_din  = hr_to_sr ? hr : in_pair;

   always_comb begin
      sr_full_nxt = sr_full;
      if (sr_load)       sr_full_nxt = 1'b1;
      else if (sr_frees) sr_full_nxt = 1'b0;
   end

   // A refill of HR in the same cycle it drains into SR keeps it full.
   always_comb begin
      hr_full_nxt = hr_full;
      if (route == ROUTE_HR) hr_full_nxt = 1'b1;
      else if (hr_to_sr)     hr_full_nxt = 1'b0;
   end

   always_comb begin
      cnt_nxt = cnt;
      if (sr_load)       cnt_nxt = '0;
      else if (sr_shift) cnt_nxt = cnt + CW'(1);
   end

   // ---- state update: control flops, counter, holding register ----
   mm_flop u_sr_full (.clk(i_clk), .rst_n(i_reset_n), .d(sr_full_nxt),  .q(sr_full));
   mm_flop u_hr_full (.clk(i_clk), .rst_n(i_reset_n), .d(hr_full_nxt),  .q(hr_full));
   // Ready is registered from the next HR state so it never combines i_rdy/i_vld.
   mm_flop u_rdy     (.clk(i_clk), .rst_n(i_reset_n), .d(!hr_full_nxt), .q(rdy));

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) cnt <= '0;
      else            cnt <= cnt_nxt;
   end

   always_ff @(posedge i_clk) begin
      if (route == ROUTE_HR) hr <= in_pair;
   end

   bitser_shreg #(.WIDTH(WIDTH)) u_shreg (
      .clk   (i_clk),
      .load  (sr_load),
      .shift (sr_shift),
      .din   (sr_din),
      .bit_a (bit_a),
      .bit_b (bit_b)
   );

   // ---- serial outputs, forced to 0 while SR is empty ----
   assign bus.o_vld  = sr_full;
   assign bus.o_A    = sr_full && bit_a;
   assign bus.o_B    = sr_full && bit_b;
   assign bus.o_last = sr_full && is_last;
   assign bus.o_rdy  = rdy;
endmodule

// File: tb/tb_bitser_tx.sv
// ---------------------------------------------------------------------------
// tb_bitser_tx
// Self-checking bench for bitser_tx at WIDTH=8 (scoreboarded) and WIDTH=1
// (directed). Accepted words are expanded into expected flits on a queue;
// every transferred flit is popped and compared.
// ---------------------------------------------------------------------------
module tb_bitser_tx;

   typedef struct packed {
      logic a;
      logic b;
      logic last;
   } flit_t;

   logic clk = 1'b0;
   logic reset_n;

   always #5 clk = ~clk;

   bitser_tx_if #(.WIDTH(8)) bus8 ();
   bitser_tx_if #(.WIDTH(1)) bus1 ();

   bitser_tx #(.WIDTH(8)) u_dut8 (.i_clk(clk), .i_reset_n(reset_n), .bus(bus8));
   bitser_tx #(.WIDTH(1)) u_dut1 (.i_clk(clk), .i_reset_n(reset_n), .bus(bus1));

   int    n_checks = 0;
   int    n_fail   = 0;
   flit_t sb[$];
   int    words_out  = 0;
   int    words_in   = 0;
   int    words_done = 0;
   bit    prev_stall = 1'b0;
   flit_t prev_flit;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Serial-side monitor / scoreboard for the WIDTH=8 instance.
   always @(negedge clk) begin
      flit_t cur, exp;
      cur = '{a: bus8.o_A, b: bus8.o_B, last: bus8.o_last};
      if (!reset_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_vld", 32'(bus8.o_vld), 32'd1);
            check("stall_data", 32'(cur), 32'(prev_flit));
         end
         if (!bus8.o_vld) check("idle_zero", 32'(cur), 32'd0);
         if (bus8.o_vld && bus8.i_rdy) begin
            if (sb.size() == 0) begin
               check("unexpected_flit", 32'(cur), 32'hFFFF);
            end else begin
               exp = sb.pop_front();
               check("flit", 32'(cur), 32'(exp));
               if (exp.last) begin
                  words_out--;
                  words_done++;
               end
            end
         end
         if (bus8.i_vld && bus8.o_rdy) begin
            check("outstanding_le2", 32'(words_out < 2), 32'd1);
            for (int k = 0; k < 8; k++) begin
               sb.push_back('{a: bus8.i_A[k], b: bus8.i_B[k], last: (k == 7)});
            end
            words_out++;
            words_in++;
         end
         prev_stall = bus8.o_vld && !bus8.i_rdy;
         prev_flit  = cur;
      end
   end

   // Present a word from just after a rising edge until it is accepted.
   task automatic send8(input logic [7:0] a, input logic [7:0] b);
      bit done;
      done = 1'b0;
      bus8.i_A   = a;
      bus8.i_B   = b;
      bus8.i_vld = 1'b1;
      for (int t = 0; t < 300 && !done; t++) begin
         @(negedge clk);
         if (bus8.o_rdy) done = 1'b1;
         @(posedge clk);
         #1;
      end
      if (!done) check("send_timeout", 32'd0, 32'd1);
      bus8.i_vld = 1'b0;
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while ((sb.size() != 0 || bus8.o_vld) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      check("drain", 32'(sb.size() == 0 && !bus8.o_vld), 32'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int exp_a [8] = '{0, 1, 0, 1, 1, 0, 1, 0};
      int exp_b [8] = '{0, 0, 1, 1, 1, 1, 0, 0};
      bit seen;
      int n;
      int done_before;
      bit rnd_on;

      reset_n    = 1'b0;
      bus8.i_A   = '0; bus8.i_B = '0; bus8.i_vld = 1'b0; bus8.i_rdy = 1'b0;
      bus1.i_A   = '0; bus1.i_B = '0; bus1.i_vld = 1'b0; bus1.i_rdy = 1'b0;

      // ---- reset values ----
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_vld",  32'(bus8.o_vld),  32'd0);
      check("rst_last", 32'(bus8.o_last), 32'd0);
      check("rst_a",    32'(bus8.o_A),    32'd0);
      check("rst_b",    32'(bus8.o_B),    32'd0);
      check("rst_rdy",  32'(bus8.o_rdy),  32'd0);
      check("rst_rdy_w1", 32'(bus1.o_rdy), 32'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(negedge clk);
      check("rdy_before_release_edge", 32'(bus8.o_rdy), 32'd0);
      @(negedge clk);
      check("rdy_after_release", 32'(bus8.o_rdy), 32'd1);
      @(posedge clk);
      #1;

      // ---- single word 0x5A/0x3C ----
      bus8.i_rdy = 1'b1;
      send8(8'h5A, 8'h3C);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check("w5a_vld",  32'(bus8.o_vld),  32'd1);
         check("w5a_a",    32'(bus8.o_A),    32'(exp_a[k]));
         check("w5a_b",    32'(bus8.o_B),    32'(exp_b[k]));
         check("w5a_last", 32'(bus8.o_last), 32'(k == 7));
      end
      @(negedge clk);
      check("w5a_vld_after", 32'(bus8.o_vld), 32'd0);
      @(posedge clk);
      #1;

      // ---- three words back to back ----
      fork
         begin
            send8(8'h01, 8'hFF);
            send8(8'h80, 8'h00);
            send8(8'hFF, 8'h01);
         end
         begin
            seen = 1'b0;
            for (int t = 0; t < 10 && !seen; t++) begin
               @(negedge clk);
               if (bus8.o_vld) seen = 1'b1;
            end
            check("burst_start", 32'(seen), 32'd1);
            for (int k = 0; k < 24; k++) begin
               if (k > 0) @(negedge clk);
               check("burst_vld",  32'(bus8.o_vld),  32'd1);
               check("burst_last", 32'(bus8.o_last), 32'((k % 8) == 7));
            end
            @(negedge clk);
            check("burst_vld_after", 32'(bus8.o_vld), 32'd0);
         end
      join
      wait_drain();

      // ---- serial side held: SR + HR fill, third word waits ----
      bus8.i_rdy = 1'b0;
      send8(8'hA5, 8'h0F);
      send8(8'h3C, 8'hC3);
      bus8.i_A = 8'h77; bus8.i_B = 8'h11; bus8.i_vld = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("hold_rdy_low", 32'(bus8.o_rdy), 32'd0);
         check("hold_vld",     32'(bus8.o_vld), 32'd1);
      end
      @(posedge clk);
      #1;
      bus8.i_rdy = 1'b1;
      seen = 1'b0;
      n = 0;
      for (int t = 0; t < 40 && !seen; t++) begin
         @(negedge clk);
         if (bus8.o_rdy) seen = 1'b1;
         else if (bus8.o_vld && bus8.i_rdy) n++;
      end
      check("hold_rdy_rises", 32'(seen), 32'd1);
      check("hold_flits_before_rdy", 32'(n), 32'd8);
      @(posedge clk);
      #1;
      bus8.i_vld = 1'b0;
      wait_drain();

      // ---- new word arrives on the cycle the last flit leaves ----
      send8(8'hFE, 8'h7F);
      repeat (7) @(posedge clk);
      #1;
      bus8.i_A = 8'h01; bus8.i_B = 8'h02; bus8.i_vld = 1'b1;
      @(negedge clk);
      check("sim_last", 32'(bus8.o_last), 32'd1);
      check("sim_rdy",  32'(bus8.o_rdy),  32'd1);
      @(posedge clk);
      #1;
      bus8.i_vld = 1'b0;
      @(negedge clk);
      check("sim_next_vld",  32'(bus8.o_vld),  32'd1);
      check("sim_next_a",    32'(bus8.o_A),    32'd1);
      check("sim_next_b",    32'(bus8.o_B),    32'd0);
      check("sim_next_last", 32'(bus8.o_last), 32'd0);
      @(posedge clk);
      #1;
      wait_drain();

      // ---- reset mid-word with HR full ----
      bus8.i_rdy = 1'b0;
      send8(8'h55, 8'hAA);
      send8(8'h99, 8'h66);
      bus8.i_rdy = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b0;
      sb.delete();
      words_out = 0;
      @(negedge clk);
      check("mid_flit3_present", 32'(bus8.o_vld), 32'd1);
      @(negedge clk);
      check("mid_rst_vld",  32'(bus8.o_vld),  32'd0);
      check("mid_rst_rdy",  32'(bus8.o_rdy),  32'd0);
      check("mid_rst_last", 32'(bus8.o_last), 32'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(negedge clk);
      check("mid_rdy_pre", 32'(bus8.o_rdy), 32'd0);
      @(negedge clk);
      check("mid_rdy_post", 32'(bus8.o_rdy), 32'd1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("mid_no_stale", 32'(bus8.o_vld), 32'd0);
      end
      @(posedge clk);
      #1;

      // ---- random serial backpressure, 100 random words ----
      done_before = words_done;
      rnd_on = 1'b1;
      fork
         begin
            for (int w = 0; w < 100; w++) begin
               int g;
               g = $urandom_range(0, 3);
               repeat (g) begin
                  @(posedge clk);
                  #1;
               end
               send8(8'($urandom), 8'($urandom));
            end
            rnd_on = 1'b0;
         end
         begin
            while (rnd_on) begin
               @(posedge clk);
               #1;
               bus8.i_rdy = 1'($urandom_range(0, 1));
            end
         end
      join
      bus8.i_rdy = 1'b1;
      wait_drain();
      check("rand_words_done", 32'(words_done - done_before), 32'd100);
      check("rand_in_eq_done", 32'(words_in - words_done), 32'd2);

      // ---- WIDTH=1: every flit is last ----
      bus1.i_rdy = 1'b1;
      bus1.i_A = 1'b1; bus1.i_B = 1'b0; bus1.i_vld = 1'b1;
      @(negedge clk);
      check("w1_rdy", 32'(bus1.o_rdy), 32'd1);
      @(posedge clk);
      #1;
      bus1.i_A = 1'b0; bus1.i_B = 1'b1;
      @(negedge clk);
      check("w1_f0_vld",  32'(bus1.o_vld),  32'd1);
      check("w1_f0_a",    32'(bus1.o_A),    32'd1);
      check("w1_f0_b",    32'(bus1.o_B),    32'd0);
      check("w1_f0_last", 32'(bus1.o_last), 32'd1);
      check("w1_rdy2",    32'(bus1.o_rdy),  32'd1);
      @(posedge clk);
      #1;
      bus1.i_vld = 1'b0;
      @(negedge clk);
      check("w1_f1_vld",  32'(bus1.o_vld),  32'd1);
      check("w1_f1_a",    32'(bus1.o_A),    32'd0);
      check("w1_f1_b",    32'(bus1.o_B),    32'd1);
      check("w1_f1_last", 32'(bus1.o_last), 32'd1);
      @(negedge clk);
      check("w1_idle", 32'(bus1.o_vld), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
